// File: rtl/irq_arbiter.sv
// irq_arbiter
//   Sequential external-interrupt arbiter. Device interrupt lines are edge
//   detected into sticky pending bits. The lowest-index pending source that
//   is enabled by the mask is presented to the core as ExtIRQ. Each request
//   then goes through acknowledge (ExtIAck) and handler return (ERet), so
//   only one external interrupt is ever outstanding.
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-low
//   irq_src     in   [N_SRC]  device interrupt levels (event = 0->1)
//   mask_we     in   mask write strobe
//   mask_wdata  in   [N_SRC]  new enable mask (1 = enabled)
//   ExtIAck     in   core acknowledge of the current request
//   ERet        in   core returned from the handler
//   ExtIRQ      out  interrupt request to the core
//   irq_id      out  [clog2(N_SRC)]  requested / serviced source index
//   src_ack     out  [N_SRC]  one-hot, one-cycle acknowledge to the device
//   pending     out  [N_SRC]  sticky pending bits
//   mask        out  [N_SRC]  current enable mask
module irq_arbiter #(
  parameter int unsigned      N_SRC    = 4,
  parameter logic [N_SRC-1:0] MASK_RST = '1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SRC-1:0]         irq_src,
  input  logic                     mask_we,
  input  logic [N_SRC-1:0]         mask_wdata,
  input  logic                     ExtIAck,
  input  logic                     ERet,
  output logic                     ExtIRQ,
  output logic [$clog2(N_SRC)-1:0] irq_id,
  output logic [N_SRC-1:0]         src_ack,
  output logic [N_SRC-1:0]         pending,
  output logic [N_SRC-1:0]         mask
);

  localparam int unsigned IW = $clog2(N_SRC);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQUEST = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [IW-1:0]    id_q,      id_d;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q,    mask_d;
  logic [N_SRC-1:0] ack_q,     ack_d;

  logic [N_SRC-1:0] event_v;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] id_onehot;
  logic             win_valid;
  logic [IW-1:0]    win_idx;

  always_comb begin
    event_v   = irq_src & ~prev_q;
    elig      = pending_q & mask_q;
    id_onehot = {{(N_SRC-1){1'b0}}, 1'b1} << id_q;

    // Fixed priority: first set bit from index 0 upward wins.
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (elig[i] && !win_valid) begin
        win_valid = 1'b1;
        win_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    ack_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          state_d = S_REQUEST;
          id_d    = win_idx;
        end
      end
      S_REQUEST: begin
        if (ExtIAck) begin
          clr     = id_onehot;
          ack_d   = id_onehot;
          state_d = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (ERet) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new event on the source being cleared in the same cycle keeps it pending.
    pending_d = (pending_q & ~clr) | event_v;
    mask_d    = mask_we ? mask_wdata : mask_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RST;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      prev_q    <= irq_src;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      ack_q     <= ack_d;
    end
  end

  assign ExtIRQ  = (state_q == S_REQUEST);
  assign irq_id  = id_q;
  assign src_ack = ack_q;
  assign pending = pending_q;
  assign mask    = mask_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Testbench for irq_arbiter: directed scenarios with constant expectations
// followed by randomized traffic compared against a behavioural model.
module tb_irq_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_src;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic         ExtIAck;
  logic         ERet;
  logic         ExtIRQ;
  logic [1:0]   irq_id;
  logic [N-1:0] src_ack;
  logic [N-1:0] pending;
  logic [N-1:0] mask;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0 = idle, 1 = requesting, 2 = in handler.
  int           m_phase;
  int           m_id;
  logic [N-1:0] m_pend, m_mask, m_prev, m_ack;

  irq_arbiter #(.N_SRC(4), .MASK_RST(4'b1111)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .ExtIAck(ExtIAck), .ERet(ERet), .ExtIRQ(ExtIRQ),
    .irq_id(irq_id), .src_ack(src_ack), .pending(pending), .mask(mask)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    logic [N-1:0] rises, cleared, ready;
    if (!reset) begin
      m_phase = 0; m_id = 0; m_ack = '0; m_pend = '0; m_mask = '1; m_prev = '0;
    end else begin
      rises   = irq_src & ~m_prev;
      ready   = m_pend & m_mask;
      cleared = '0;
      m_ack   = '0;
      if (m_phase == 0) begin
        if (ready != 0) begin
          for (int i = N - 1; i >= 0; i--) if (ready[i]) m_id = i;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (ExtIAck) begin
          cleared[m_id] = 1'b1;
          m_ack[m_id]   = 1'b1;
          m_phase       = 2;
        end
      end else if (ERet) begin
        m_phase = 0;
      end
      m_pend = (m_pend & ~cleared) | rises;
      m_prev = irq_src;
      if (mask_we) m_mask = mask_wdata;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b1; irq_src = '0; mask_we = 1'b0; mask_wdata = '0;
    ExtIAck = 1'b0; ERet = 1'b0;
  endtask

  task automatic clean_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0; irq_src = 4'b1111;
    tick(); tick();
    checks++; if (ExtIRQ !== 1'b0) begin errors++; $display("FAIL reset_extirq got %b exp 0", ExtIRQ); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got %b exp 0000", pending); end
    checks++; if (mask !== 4'b1111) begin errors++; $display("FAIL reset_mask got %b exp 1111", mask); end
    checks++; if (src_ack !== 4'b0000 || irq_id !== 2'd0) begin errors++; $display("FAIL reset_ack_id got %b/%0d exp 0000/0", src_ack, irq_id); end
    reset = 1'b1;
    tick();
    checks++; if (pending !== 4'b1111) begin errors++; $display("FAIL reset_release_pending got %b exp 1111", pending); end
  endtask

  task automatic test_single();
    clean_reset();
    irq_src = 4'b0100;
    tick();
    irq_src = 4'b0000;
    checks++; if (ExtIRQ !== 1'b0 || pending !== 4'b0100) begin errors++; $display("FAIL single_e0 got irq=%b pend=%b exp 0/0100", ExtIRQ, pending); end
    tick();
    checks++; if (ExtIRQ !== 1'b1 || irq_id !== 2'd2) begin errors++; $display("FAIL single_req got irq=%b id=%0d exp 1/2", ExtIRQ, irq_id); end
    tick();
    checks++; if (ExtIRQ !== 1'b1) begin errors++; $display("FAIL single_hold got %b exp 1", ExtIRQ); end
    ExtIAck = 1'b1;
    tick();
    ExtIAck = 1'b0;
    checks++; if (src_ack !== 4'b0100 || pending !== 4'b0000 || ExtIRQ !== 1'b0) begin errors++; $display("FAIL single_ack got ack=%b pend=%b irq=%b exp 0100/0000/0", src_ack, pending, ExtIRQ); end
    tick();
    checks++; if (src_ack !== 4'b0000 || irq_id !== 2'd2) begin errors++; $display("FAIL single_ack_pulse got ack=%b id=%0d exp 0000/2", src_ack, irq_id); end
    ERet = 1'b1;
    tick();
    ERet = 1'b0;
    tick();
    checks++; if (ExtIRQ !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", ExtIRQ); end
  endtask

  task automatic test_priority();
    clean_reset();
    irq_src = 4'b1000; tick();
    irq_src = 4'b0000; tick();
    checks++; if (ExtIRQ !== 1'b1 || irq_id !== 2'd3) begin errors++; $display("FAIL prio_req3 got irq=%b id=%0d exp 1/3", ExtIRQ, irq_id); end
    irq_src = 4'b0001; tick();
    irq_src = 4'b0000; tick();
    checks++; if (ExtIRQ !== 1'b1 || irq_id !== 2'd3 || pending !== 4'b1001) begin errors++; $display("FAIL prio_commit got irq=%b id=%0d pend=%b exp 1/3/1001", ExtIRQ, irq_id, pending); end
    ExtIAck = 1'b1; tick(); ExtIAck = 1'b0;
    checks++; if (src_ack !== 4'b1000) begin errors++; $display("FAIL prio_ack3 got %b exp 1000", src_ack); end
    ERet = 1'b1; tick(); ERet = 1'b0;
    checks++; if (ExtIRQ !== 1'b0) begin errors++; $display("FAIL prio_gap got %b exp 0", ExtIRQ); end
    tick();
    checks++; if (ExtIRQ !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL prio_req0 got irq=%b id=%0d exp 1/0", ExtIRQ, irq_id); end
  endtask

  task automatic test_mask();
    clean_reset();
    mask_we = 1'b1; mask_wdata = 4'b1110; tick(); mask_we = 1'b0;
    checks++; if (mask !== 4'b1110) begin errors++; $display("FAIL mask_write got %b exp 1110", mask); end
    irq_src = 4'b0001; tick();
    irq_src = 4'b0000; tick(); tick();
    checks++; if (pending !== 4'b0001 || ExtIRQ !== 1'b0) begin errors++; $display("FAIL mask_block got pend=%b irq=%b exp 0001/0", pending, ExtIRQ); end
    mask_we = 1'b1; mask_wdata = 4'b1111; tick(); mask_we = 1'b0;
    checks++; if (ExtIRQ !== 1'b0 || mask !== 4'b1111) begin errors++; $display("FAIL mask_w_edge got irq=%b mask=%b exp 0/1111", ExtIRQ, mask); end
    tick();
    checks++; if (ExtIRQ !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL mask_req got irq=%b id=%0d exp 1/0", ExtIRQ, irq_id); end
    mask_we = 1'b1; mask_wdata = 4'b0000; tick(); mask_we = 1'b0;
    checks++; if (ExtIRQ !== 1'b1 || irq_id !== 2'd0) begin errors++; $display("FAIL mask_commit got irq=%b id=%0d exp 1/0", ExtIRQ, irq_id); end
  endtask

  task automatic test_collision();
    clean_reset();
    irq_src = 4'b0010; tick();
    irq_src = 4'b0000; tick();
    checks++; if (ExtIRQ !== 1'b1 || irq_id !== 2'd1) begin errors++; $display("FAIL coll_req got irq=%b id=%0d exp 1/1", ExtIRQ, irq_id); end
    ExtIAck = 1'b1; irq_src = 4'b0010; tick();
    ExtIAck = 1'b0; irq_src = 4'b0000;
    checks++; if (pending !== 4'b0010 || src_ack !== 4'b0010 || ExtIRQ !== 1'b0) begin errors++; $display("FAIL coll_setwins got pend=%b ack=%b irq=%b exp 0010/0010/0", pending, src_ack, ExtIRQ); end
    ERet = 1'b1; tick(); ERet = 1'b0; tick();
    checks++; if (ExtIRQ !== 1'b1 || irq_id !== 2'd1) begin errors++; $display("FAIL coll_rereq got irq=%b id=%0d exp 1/1", ExtIRQ, irq_id); end
  endtask

  task automatic test_mid_reset();
    clean_reset();
    irq_src = 4'b0100; tick();
    irq_src = 4'b0000; tick();
    ExtIAck = 1'b1; tick(); ExtIAck = 1'b0;
    reset = 1'b0; tick(); reset = 1'b1;
    checks++; if (ExtIRQ !== 1'b0 || pending !== 4'b0000 || src_ack !== 4'b0000 || irq_id !== 2'd0) begin errors++; $display("FAIL midrst_state got irq=%b pend=%b ack=%b id=%0d exp 0/0000/0000/0", ExtIRQ, pending, src_ack, irq_id); end
    ERet = 1'b1; tick(); ERet = 1'b0;
    ExtIAck = 1'b1; tick(); ExtIAck = 1'b0;
    checks++; if (ExtIRQ !== 1'b0 || src_ack !== 4'b0000 || pending !== 4'b0000) begin errors++; $display("FAIL midrst_ignore got irq=%b ack=%b pend=%b exp 0/0000/0000", ExtIRQ, src_ack, pending); end
  endtask

  task automatic test_random();
    int bad;
    clean_reset();
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 49) != 0);
      irq_src    = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      mask_we    = ($urandom_range(0, 9) == 0);
      mask_wdata = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      ExtIAck    = ($urandom_range(0, 1) == 1);
      ERet       = ($urandom_range(0, 2) == 0);
      tick();
      bad = 0;
      checks++;
      if (ExtIRQ !== (m_phase == 1)) bad = 1;
      if (irq_id !== 2'(m_id)) bad = 1;
      if (src_ack !== m_ack) bad = 1;
      if (pending !== m_pend) bad = 1;
      if (mask !== m_mask) bad = 1;
      if (bad != 0) begin
        errors++;
        $display("FAIL random cyc %0d got irq=%b id=%0d ack=%b pend=%b mask=%b exp irq=%b id=%0d ack=%b pend=%b mask=%b",
                 c, ExtIRQ, irq_id, src_ack, pending, mask, (m_phase == 1), m_id, m_ack, m_pend, m_mask);
      end
    end
  endtask

  initial begin
    idle_inputs();
    m_phase = 0; m_id = 0; m_ack = '0; m_pend = '0; m_mask = '1; m_prev = '0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_collision();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Sequential external-interrupt arbiter for the single-cycle processor with exceptions. It collects up to `N_SRC` device interrupt lines and latches each new event as pending. It then presents one request at a time on the core's `ExtIRQ` input, which feeds the controller's `Exc` and `EStatus` logic. It sequences each interrupt through acknowledge (`ExtIAck`) and handler return (`ERet`), so the core only ever sees one outstanding external interrupt.

## Interface
- `N_SRC`, default 4: number of interrupt sources, 2..16.
- `MASK_RST`, default all ones: reset value of the enable mask.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low; the block is in reset while `reset`=0 at a rising edge.
- `irq_src`  in  N_SRC: device interrupt lines, level input, event = 0→1 transition.
- `mask_we`  in  1: mask write strobe.
- `mask_wdata`  in  N_SRC: new enable mask (1 = enabled).
- `ExtIAck`  in  1: core acknowledge of the current external interrupt.
- `ERet`  in  1: core executed ERET, handler finished.
- `ExtIRQ`  out  1: interrupt request to core.
- `irq_id`  out  $clog2(N_SRC): index of the requested or serviced source.
- `src_ack`  out  N_SRC: one-hot, one-cycle acknowledge back to the serviced device.
- `pending`  out  N_SRC: sticky pending bits, for status readout.
- `mask`  out  N_SRC: current enable mask.

## Operation
- Edge detect: `prev` register holds last `irq_src`. Event on source i = `irq_src[i]` & ~`prev[i]`. An event sets `pending[i]` at that edge, regardless of mask.
- Mask: `mask_we`=1 loads `mask_wdata` at the edge. Masked pending bits stay pending but are not eligible.
- Eligible vector = `pending` & `mask`. Priority is fixed: lowest index wins.
- FSM states:
  - IDLE: `ExtIRQ`=0. If the eligible vector is nonzero, go to REQUEST and latch the winner into `irq_id`.
  - REQUEST: `ExtIRQ`=1 and `irq_id` held stable. On `ExtIAck`=1:
    - clear `pending[irq_id]`;
    - pulse `src_ack[irq_id]` next cycle;
    - go to SERVICE.
  - SERVICE: `ExtIRQ`=0 and `irq_id` held. On `ERet`=1, go to IDLE.
- Request is committed once in REQUEST. Masking the source or a higher-priority arrival does not change `irq_id` or drop `ExtIRQ`.
- Ignored inputs: `ExtIAck` in IDLE or SERVICE; `ERet` in IDLE or REQUEST.
- Simultaneous new event on a source and clear of that same source in one cycle: set wins, so `pending` stays 1.
- Source deassertion after its event does not clear `pending`.

## Timing
- Reset (`reset`=0 at an edge), applied from any state including mid-REQUEST or SERVICE:
  - state=IDLE, `ExtIRQ`=0, `irq_id`=0;
  - `src_ack`=0, `pending`=0;
  - `mask`=`MASK_RST`, `prev`=0.
  - A source held high through reset registers one event on the first edge after reset release.
- Latency:
  - `irq_src` 0→1 sampled at edge E0 → `pending` set after E0.
  - With IDLE and the source eligible, `ExtIRQ`=1 after E1.
- `ExtIAck` sampled at edge A → after A: `ExtIRQ`=0, `pending` bit cleared, `src_ack` one-hot high for exactly the cycle after A.
- `ERet` sampled at edge R → IDLE after R. A still-eligible pending source raises `ExtIRQ` after R+1, giving at least one idle cycle between requests.
- All outputs are registered; none are combinational from inputs.
- Throughput: at most one interrupt serviced per REQUEST→SERVICE→IDLE round. Minimum 3 cycles per interrupt.

## Test plan
- Reset: drive `reset`=0 for 2 cycles with `irq_src`=4'b1111 → `ExtIRQ`=0, `pending`=0, `mask`=4'b1111. After release, `pending`=4'b1111 one edge later.
- Single IRQ: pulse `irq_src[2]` → `ExtIRQ`=1 two edges later with `irq_id`=2. `ExtIAck` → `src_ack`=4'b0100 for 1 cycle and `pending[2]`=0. `ERet` → IDLE.
- Priority plus commitment: raise src 3, and while in REQUEST(3) raise src 0 → `irq_id` stays 3. After ack and `ERet`, next request is `irq_id`=0.
- Mask: `mask`=4'b1110, pulse src 0 → `pending[0]`=1, `ExtIRQ` stays 0. Write `mask`=4'b1111 → `ExtIRQ`=1 with `irq_id`=0 two edges after the write edge.
- Collision: src 1 re-rises on the same edge as its `ExtIAck` → `pending[1]` remains 1. After `ERet`, `irq_id`=1 is requested again.
- Mid-operation reset: assert `reset`=0 in SERVICE → IDLE with `ExtIRQ`=0. A subsequent `ERet` or `ExtIAck` has no effect.
